writeback_regfile: RTL and testbench

- Consumes the writeback-stage outputs of the MEM/WB pipeline register.
- Selects the writeback result, commits it to a 32-entry general register file, and serves the decode stage's two read ports.
- Provides write-through bypass, so a decode-stage read in the same cycle as a writeback to that register sees the new value.
- Keeps a retired-write counter and a debug read port for test benches.

---
 rtl/writeback_regfile_if.sv | 35 +++
 rtl/writeback_regfile.sv | 78 +++++++
 tb/tb_writeback_regfile.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// MEM/WB writeback and decode read-port bundle for writeback_regfile.
// The master drives the pipeline-side inputs; the slave is the register file.
interface writeback_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
);
   logic                  RegWriteW;
   logic                  MemtoRegW;
   logic                  JalW;
   logic [DATA_WIDTH-1:0] MemReadDataW;
   logic [DATA_WIDTH-1:0] ALUResultW;
   logic [DATA_WIDTH-1:0] PCPlus4W;
   logic [ADDR_WIDTH-1:0] WriteRegW;
   logic [ADDR_WIDTH-1:0] ReadReg1D;
   logic [ADDR_WIDTH-1:0] ReadReg2D;
   logic [ADDR_WIDTH-1:0] DbgRegAddr;
   logic [DATA_WIDTH-1:0] ResultW;
   logic [DATA_WIDTH-1:0] ReadData1D;
   logic [DATA_WIDTH-1:0] ReadData2D;
   logic [DATA_WIDTH-1:0] DbgRegData;
   logic [CNT_WIDTH-1:0]  WriteCount;

   modport master (
      output RegWriteW, MemtoRegW, JalW, MemReadDataW, ALUResultW, PCPlus4W,
             WriteRegW, ReadReg1D, ReadReg2D, DbgRegAddr,
      input  ResultW, ReadData1D, ReadData2D, DbgRegData, WriteCount
   );

   modport slave (
      input  RegWriteW, MemtoRegW, JalW, MemReadDataW, ALUResultW, PCPlus4W,
             WriteRegW, ReadReg1D, ReadReg2D, DbgRegAddr,
      output ResultW, ReadData1D, ReadData2D, DbgRegData, WriteCount
   );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback result select, 2**ADDR_WIDTH-entry register file with write-through
// decode reads, unbypassed debug read, and a retired-write counter.
module writeback_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input logic           Clk,
   input logic           Reset_n,
   writeback_regfile_if.slave wb
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [CNT_WIDTH-1:0]  write_count_q;
   logic [CNT_WIDTH-1:0]  write_count_d;
   logic [DATA_WIDTH-1:0] result;
   logic                  commit;
   logic                  bypass_en;

   always_comb begin
      if (wb.JalW)           result = wb.PCPlus4W;
      else if (wb.MemtoRegW) result = wb.MemReadDataW;
      else                   result = wb.ALUResultW;
   end

   assign commit    = wb.RegWriteW && (wb.WriteRegW != '0);
   // A write that reset is about to discard must not be forwarded either.
   assign bypass_en = commit && Reset_n;

   // NOTE: every output of a combinational block gets a default first, otherwise
   // a missing branch silently infers a latch.
   always_comb begin
      regs_d        = regs_q;
      write_count_d = write_count_q;
      if (commit) begin
         regs_d[wb.WriteRegW] = result;
         write_count_d        = write_count_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      wb.ReadData1D = regs_q[wb.ReadReg1D];
      if (wb.ReadReg1D == '0)
         wb.ReadData1D = '0;
      else if (bypass_en && (wb.WriteRegW == wb.ReadReg1D))
         wb.ReadData1D = result;
   end

   always_comb begin
      wb.ReadData2D = regs_q[wb.ReadReg2D];
      if (wb.ReadReg2D == '0)
         wb.ReadData2D = '0;
      else if (bypass_en && (wb.WriteRegW == wb.ReadReg2D))
         wb.ReadData2D = result;
   end

   always_comb begin
      wb.DbgRegData = regs_q[wb.DbgRegAddr];
      if (wb.DbgRegAddr == '0) wb.DbgRegData = '0;
   end

   assign wb.ResultW    = result;
   assign wb.WriteCount = write_count_q;

   // NOTE: the register array is reset because every entry must read 0 while
   // reset is held; sequential state uses non-blocking assignments only.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         write_count_q <= write_count_d;
      end
   end
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: a 32-bit-counter instance
// for datapath checks and a 4-bit-counter instance for counter wrap.
module tb_writeback_regfile;
   logic Clk;
   logic Reset_n;

   int n_tests;
   int n_fail;

   writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) wb ();
   writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  wb4 ();

   writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) u_dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .wb      (wb)
   );

   writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) u_dut_cnt4 (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .wb      (wb4)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb.RegWriteW    = 1'b0;
      wb.MemtoRegW    = 1'b0;
      wb.JalW         = 1'b0;
      wb.MemReadDataW = '0;
      wb.ALUResultW   = '0;
      wb.PCPlus4W     = '0;
      wb.WriteRegW    = '0;
      wb.ReadReg1D    = '0;
      wb.ReadReg2D    = '0;
      wb.DbgRegAddr   = '0;
      wb4.RegWriteW    = 1'b0;
      wb4.MemtoRegW    = 1'b0;
      wb4.JalW         = 1'b0;
      wb4.MemReadDataW = '0;
      wb4.ALUResultW   = '0;
      wb4.PCPlus4W     = '0;
      wb4.WriteRegW    = '0;
      wb4.ReadReg1D    = '0;
      wb4.ReadReg2D    = '0;
      wb4.DbgRegAddr   = '0;
   endtask

   task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
      wb.RegWriteW  = 1'b1;
      wb.MemtoRegW  = 1'b0;
      wb.JalW       = 1'b0;
      wb.ALUResultW = val;
      wb.WriteRegW  = rd;
      tick();
      wb.RegWriteW  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      Reset_n = 1'b0;
      idle_inputs();
      #1;
      check("reset_count", wb.WriteCount, 0);
      wb.DbgRegAddr = 5'd5;
      #1;
      check("reset_dbg_r5", wb.DbgRegData, 0);
      tick();
      tick();
      Reset_n = 1'b1;
      tick();

      // ALU writeback to r8
      wb.RegWriteW  = 1'b1;
      wb.ALUResultW = 32'h0000_00A5;
      wb.MemReadDataW = 32'h1234_5678;
      wb.WriteRegW  = 5'd8;
      #1;
      check("alu_result_sel", wb.ResultW, 32'h0000_00A5);
      tick();
      wb.RegWriteW  = 1'b0;
      wb.DbgRegAddr = 5'd8;
      #1;
      check("alu_r8", wb.DbgRegData, 32'h0000_00A5);
      check("alu_count", wb.WriteCount, 1);

      // load to r9
      wb.RegWriteW    = 1'b1;
      wb.MemtoRegW    = 1'b1;
      wb.MemReadDataW = 32'hDEAD_BEEF;
      wb.ALUResultW   = 32'h0000_1111;
      wb.PCPlus4W     = 32'h0000_2222;
      wb.WriteRegW    = 5'd9;
      #1;
      check("load_result_sel", wb.ResultW, 32'hDEAD_BEEF);
      tick();
      wb.RegWriteW  = 1'b0;
      wb.DbgRegAddr = 5'd9;
      #1;
      check("load_r9", wb.DbgRegData, 32'hDEAD_BEEF);

      // jal to r31 overrides MemtoRegW
      wb.RegWriteW  = 1'b1;
      wb.JalW       = 1'b1;
      wb.MemtoRegW  = 1'b1;
      wb.PCPlus4W   = 32'h0040_0010;
      wb.WriteRegW  = 5'd31;
      #1;
      check("jal_result_sel", wb.ResultW, 32'h0040_0010);
      tick();
      wb.RegWriteW  = 1'b0;
      wb.JalW       = 1'b0;
      wb.MemtoRegW  = 1'b0;
      wb.DbgRegAddr = 5'd31;
      #1;
      check("jal_r31", wb.DbgRegData, 32'h0040_0010);
      check("jal_count", wb.WriteCount, 3);

      // r0 protection, including during the write cycle
      wb.RegWriteW  = 1'b1;
      wb.ALUResultW = 32'hFFFF_FFFF;
      wb.WriteRegW  = 5'd0;
      wb.ReadReg1D  = 5'd0;
      wb.DbgRegAddr = 5'd0;
      #1;
      check("r0_rd1_during", wb.ReadData1D, 0);
      check("r0_dbg_during", wb.DbgRegData, 0);
      tick();
      wb.RegWriteW = 1'b0;
      #1;
      check("r0_rd1_after", wb.ReadData1D, 0);
      check("r0_dbg_after", wb.DbgRegData, 0);
      check("r0_count", wb.WriteCount, 3);

      // bypass: r4 = 0x11, then same-cycle write of 0x22
      alu_write(5'd4, 32'h11);
      wb.RegWriteW  = 1'b1;
      wb.ALUResultW = 32'h22;
      wb.WriteRegW  = 5'd4;
      wb.ReadReg1D  = 5'd4;
      wb.ReadReg2D  = 5'd4;
      wb.DbgRegAddr = 5'd4;
      #1;
      check("byp_rd1_before", wb.ReadData1D, 32'h22);
      check("byp_rd2_before", wb.ReadData2D, 32'h22);
      check("byp_dbg_before", wb.DbgRegData, 32'h11);
      tick();
      wb.RegWriteW = 1'b0;
      #1;
      check("byp_rd1_after", wb.ReadData1D, 32'h22);
      check("byp_rd2_after", wb.ReadData2D, 32'h22);
      check("byp_dbg_after", wb.DbgRegData, 32'h22);

      // no bypass when RegWriteW = 0
      alu_write(5'd4, 32'h11);
      wb.ALUResultW = 32'h22;
      wb.WriteRegW  = 5'd4;
      #1;
      check("nobyp_rd1", wb.ReadData1D, 32'h11);
      check("nobyp_rd2", wb.ReadData2D, 32'h11);

      // X data with RegWriteW = 0 leaves state alone
      wb.ALUResultW   = 'x;
      wb.MemReadDataW = 'x;
      wb.PCPlus4W     = 'x;
      wb.MemtoRegW    = 1'bx;
      wb.JalW         = 1'bx;
      tick();
      check("xsafe_r4", wb.DbgRegData, 32'h11);
      check("xsafe_count", wb.WriteCount, 6);
      wb.MemtoRegW = 1'b0;
      wb.JalW      = 1'b0;

      // independent read ports
      wb.ReadReg1D = 5'd8;
      wb.ReadReg2D = 5'd9;
      #1;
      check("indep_rd1_r8", wb.ReadData1D, 32'h0000_00A5);
      check("indep_rd2_r9", wb.ReadData2D, 32'hDEAD_BEEF);

      // reset mid-operation after writes to r5 and r31
      alu_write(5'd5, 32'h55);
      wb.DbgRegAddr = 5'd5;
      #1;
      check("pre_reset_r5", wb.DbgRegData, 32'h55);
      check("pre_reset_count", wb.WriteCount, 7);
      wb.RegWriteW  = 1'b1;
      wb.ALUResultW = 32'h77;
      wb.WriteRegW  = 5'd5;
      wb.ReadReg1D  = 5'd5;
      Reset_n       = 1'b0;
      #1;
      check("reset_r5_async", wb.DbgRegData, 0);
      check("reset_count_async", wb.WriteCount, 0);
      check("reset_rd1_nobyp", wb.ReadData1D, 0);
      wb.DbgRegAddr = 5'd31;
      #1;
      check("reset_r31_async", wb.DbgRegData, 0);
      tick();
      wb.DbgRegAddr = 5'd5;
      #1;
      check("reset_edge_r5", wb.DbgRegData, 0);
      check("reset_edge_count", wb.WriteCount, 0);
      wb.RegWriteW = 1'b0;
      Reset_n      = 1'b1;
      tick();
      check("post_reset_count", wb.WriteCount, 0);

      // counter wrap on the 4-bit instance
      wb4.RegWriteW  = 1'b1;
      wb4.WriteRegW  = 5'd1;
      wb4.DbgRegAddr = 5'd1;
      for (int i = 1; i <= 17; i++) begin
         wb4.ALUResultW = 32'(i);
         tick();
         if (i == 15) check("wrap_15", wb4.WriteCount, 15);
         if (i == 16) check("wrap_16", wb4.WriteCount, 0);
         if (i == 17) check("wrap_17", wb4.WriteCount, 1);
      end
      wb4.RegWriteW = 1'b0;
      #1;
      check("wrap_r1_data", wb4.DbgRegData, 17);
      check("wrap_main_count", wb.WriteCount, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
